// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg
//   Shared definitions for the round-robin arbiter slice.
//   - gpreg    : default payload type carried on the decoupled ports
//   - wrap_inc : modulo-n increment used for rotating scan start points
package rr_arbiter_pkg;

  typedef logic [31:0] gpreg;

  // Next index after v in a ring of n entries.
  // Written as a compare instead of %, so it stays cheap for any n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotating priority encoder. It scans valid[start],
//   valid[start+1], ... modulo N and reports the first set bit.
//   Ports:
//     valid [N]         candidate vector
//     start [clog2(N)]  index checked first
//     found             at least one candidate is set
//     idx   [clog2(N)]  first set index at or after start (0 when !found)
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // The !found guard keeps the earliest hit in scan order. The modulo
  // keeps every candidate index below N, even for non-power-of-two N.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(start) + k) % N);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. It shares one decoupled sink among N decoupled
//   requesters with zero latency. The grant is held while the sink
//   stalls. An optional burst mode lets one winner keep the grant for up
//   to BURST consecutive beats.
//   Ports:
//     clk, rst      clock; synchronous active-high reset
//     req_valid[N]  requester valid
//     req_ready[N]  requester ready (at most one high per cycle)
//     req_data[N]   requester payload
//     out_valid     sink valid (OR of all requester valids)
//     out_ready     sink ready
//     out_data      payload of the selected requester
//     flush         clears arbitration state, like rst
//     grant_idx     selected index; meaningful only while out_valid
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter type Data  = gpreg,
  parameter int  N     = 2,
  parameter int  BURST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  Data                  req_data [N],
  output logic                 out_valid,
  input  logic                 out_ready,
  output Data                  out_data,
  input  logic                 flush,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BURST + 1);

  if (N < 2) begin : g_bad_n
    $error("rr_arbiter: N must be at least 2");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("rr_arbiter: BURST must be at least 1");
  end

  logic [IW-1:0] ptr;
  logic          hold;
  logic [IW-1:0] owner;
  logic [BW-1:0] beats;

  logic          owner_live;
  logic [IW-1:0] scan_start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel;
  logic [BW-1:0] cur_beats;

  // A pinned owner that dropped valid loses its pin at once. The scan
  // then restarts just past that owner, not past the last winner.
  assign owner_live = hold && req_valid[owner];
  assign scan_start = hold ? IW'(wrap_inc(int'(owner), N))
                           : IW'(wrap_inc(int'(ptr), N));

  rr_pick #(.N(N)) u_pick (
    .valid (req_valid),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel       = owner_live ? owner : pick_idx;
  assign out_valid = owner_live || pick_found;
  assign out_data  = req_data[sel];
  assign grant_idx = sel;

  // The beat count belongs to the live owner only. A requester that
  // takes over from a dropped owner starts a fresh burst.
  assign cur_beats = owner_live ? beats : '0;

  always_comb begin
    req_ready = '0;
    if (out_valid && out_ready) req_ready[sel] = 1'b1;
  end

  // Order of updates: flush/reset, then stall (pin the grant), then a
  // handshake (extend or end the burst), then release of a dropped
  // owner. With no request and no pin, the state stays unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr   <= IW'(N - 1);
      hold  <= 1'b0;
      owner <= '0;
      beats <= '0;
    end else if (out_valid && !out_ready) begin
      hold  <= 1'b1;
      owner <= sel;
      beats <= cur_beats;
    end else if (out_valid) begin
      if (int'(cur_beats) + 1 < BURST) begin
        hold  <= 1'b1;
        owner <= sel;
        beats <= cur_beats + BW'(1);
      end else begin
        hold  <= 1'b0;
        beats <= '0;
        ptr   <= sel;
      end
    end else if (hold) begin
      hold  <= 1'b0;
      beats <= '0;
      ptr   <= owner;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter
//   Drives three arbiters in lockstep from one stimulus stream:
//     A: N=4, BURST=1   B: N=4, BURST=3   C: N=3, BURST=1
//   A reference model checks every output of every instance on every
//   cycle. A table of vectors and a few hand-written sequences pin down
//   the expected grant orders.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, outReady;
  logic [3:0] reqValid;
  gpreg       reqData  [4];
  gpreg       reqData3 [3];

  always_comb begin
    for (int i = 0; i < 3; i++) reqData3[i] = reqData[i];
  end

  logic [3:0] readyA, readyB;
  logic [2:0] readyC;
  logic       validA, validB, validC;
  gpreg       dataA, dataB, dataC;
  logic [1:0] grantA, grantB, grantC;

  rr_arbiter #(.N(4), .BURST(1)) dutA (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(readyA),
    .req_data(reqData), .out_valid(validA), .out_ready(outReady),
    .out_data(dataA), .flush(flush), .grant_idx(grantA));

  rr_arbiter #(.N(4), .BURST(3)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(readyB),
    .req_data(reqData), .out_valid(validB), .out_ready(outReady),
    .out_data(dataB), .flush(flush), .grant_idx(grantB));

  rr_arbiter #(.N(3), .BURST(1)) dutC (
    .clk(clk), .rst(rst), .req_valid(reqValid[2:0]), .req_ready(readyC),
    .req_data(reqData3), .out_valid(validC), .out_ready(outReady),
    .out_data(dataC), .flush(flush), .grant_idx(grantC));

  int checks = 0;
  int errors = 0;

  // Model state: the last winner, the pinned requester (-1 when none),
  // and the beats that the pinned requester has already used.
  typedef struct {
    int last;
    int pin;
    int beats;
  } mstate_t;

  mstate_t mA, mB, mC;

  function automatic mstate_t modelReset(input int n);
    mstate_t s;
    s.last  = n - 1;
    s.pin   = -1;
    s.beats = 0;
    return s;
  endfunction

  function automatic int modelSel(input mstate_t s, input int n, input logic [3:0] v);
    int base;
    if (s.pin >= 0 && v[s.pin]) return s.pin;
    base = (s.pin >= 0) ? s.pin : s.last;
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (base + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t modelNext(input mstate_t s, input int n, input int burst,
                                        input logic [3:0] v, input logic rdy,
                                        input logic fl, input logic rs);
    mstate_t nx;
    int sel, used;
    if (fl || rs) return modelReset(n);
    nx   = s;
    sel  = modelSel(s, n, v);
    used = (s.pin >= 0 && sel == s.pin) ? s.beats : 0;
    if (sel < 0) begin
      if (s.pin >= 0) begin
        nx.last  = s.pin;
        nx.pin   = -1;
        nx.beats = 0;
      end
    end else if (!rdy) begin
      nx.pin   = sel;
      nx.beats = used;
    end else if (used + 1 < burst) begin
      nx.pin   = sel;
      nx.beats = used + 1;
    end else begin
      nx.last  = sel;
      nx.pin   = -1;
      nx.beats = 0;
    end
    return nx;
  endfunction

  task automatic expectVal(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic fl,
                               input logic rs, input bit randData);
    reqValid = v;
    outReady = rdy;
    flush    = fl;
    rst      = rs;
    for (int i = 0; i < 4; i++)
      reqData[i] = randData ? gpreg'($urandom) : 32'hA000_0000 + 32'(i);
    #2;
  endtask

  task automatic checkDut(input string nm, input int n, input mstate_t s, input logic vo,
                          input logic [1:0] g, input gpreg d, input logic [3:0] rv);
    int sel;
    logic [3:0] expReady;
    sel = modelSel(s, n, reqValid);
    expReady = (outReady && sel >= 0) ? (4'b0001 << sel) : 4'b0000;
    expectVal({nm, " out_valid"}, 32'(vo), 32'(sel >= 0));
    expectVal({nm, " req_ready"}, 32'(rv), 32'(expReady));
    if (sel >= 0) begin
      expectVal({nm, " grant_idx"}, 32'(g), 32'(sel));
      expectVal({nm, " out_data"}, d, reqData[sel]);
    end
  endtask

  task automatic checkOutput();
    checkDut("A", 4, mA, validA, grantA, dataA, readyA);
    checkDut("B", 4, mB, validB, grantB, dataB, readyB);
    checkDut("C", 3, mC, validC, grantC, dataC, {1'b0, readyC});
  endtask

  task automatic advance();
    mA = modelNext(mA, 4, 1, reqValid, outReady, flush, rst);
    mB = modelNext(mB, 4, 3, reqValid, outReady, flush, rst);
    mC = modelNext(mC, 3, 1, reqValid, outReady, flush, rst);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ready;
    logic       expValid;
    logic [1:0] expGrant;
    logic [3:0] expReady;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Expected outputs of arbiter A (N=4, BURST=1), starting from reset.
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[6]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
    vecs[7]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
    vecs[8]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
    vecs[9]  = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[10] = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[11] = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};

    // Initial reset. The state is unknown before this edge, so the
    // outputs are not compared yet.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    mA = modelReset(4);
    mB = modelReset(4);
    mC = modelReset(3);
    @(posedge clk);
    #1;

    // Table vectors for arbiter A. The held data is fixed, so out_data
    // must equal req1's payload during the stall.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].valid, vecs[k].ready, 1'b0, 1'b0, 1'b0);
      checkOutput();
      expectVal($sformatf("table%0d out_valid", k), 32'(validA), 32'(vecs[k].expValid));
      expectVal($sformatf("table%0d req_ready", k), 32'(readyA), 32'(vecs[k].expReady));
      if (vecs[k].expValid) begin
        expectVal($sformatf("table%0d grant", k), 32'(grantA), 32'(vecs[k].expGrant));
        expectVal($sformatf("table%0d data", k), dataA, 32'hA000_0000 + 32'(vecs[k].expGrant));
      end
      advance();
    end

    // Burst order on B and the N=3 wrap-around on C, from reset.
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    advance();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput();
      expectVal($sformatf("B burst beat%0d", k), 32'(grantB), 32'(k / 3));
      expectVal($sformatf("C wrap beat%0d", k), 32'(grantC), 32'(k % 3));
      advance();
    end

    // Req0 ends its burst after one beat: the grant moves to 1 at once.
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    advance();
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput();
    expectVal("B early first", 32'(grantB), 32'd0);
    advance();
    applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput();
    expectVal("B early switch", 32'(grantB), 32'd1);
    advance();

    // Stall pins A on req2. A flush then restarts priority at req0.
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    advance();
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    expectVal("flush pin", 32'(grantA), 32'd2);
    advance();
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput();
    expectVal("flush cycle", 32'(grantA), 32'd2);
    advance();
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput();
    expectVal("after flush A", 32'(grantA), 32'd0);
    expectVal("after flush B", 32'(grantB), 32'd0);
    advance();

    // Reset in the middle of req1's burst on B. Req0 then gets a full
    // fresh burst, which shows that the beat count was cleared.
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    advance();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput();
      expectVal("B req1 beat", 32'(grantB), 32'd1);
      advance();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    advance();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput();
      expectVal($sformatf("B post-rst beat%0d", k), 32'(grantB), (k < 3) ? 32'd0 : 32'd1);
      advance();
    end

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, 1'b1);
      checkOutput();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
